// File: rtl/seq_mem_pkg.sv
// Shared definitions for the sequential memory blocks: recorder state encoding
// and index-width helpers also used by the sequential ROM reader.
package seq_mem_pkg;

  typedef enum logic {
    ST_REC  = 1'b0,
    ST_DUMP = 1'b1
  } seq_state_t;

  // Width of an index that must be able to hold the value depth itself.
  function automatic int idx_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a plain memory address (0 .. depth-1), never below one bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_1w1r.sv
// W x SIZE storage array: one synchronous write port, one asynchronous read port.
// Contents are never cleared; reads past the last entry return zero.
module ram_1w1r
  import seq_mem_pkg::*;
#(
  parameter int W    = 8,
  parameter int SIZE = 256,
  parameter int RAW  = addr_width(SIZE)
) (
  input  logic           clock,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [W-1:0]   wdata,
  input  logic [RAW-1:0] raddr,
  output logic [W-1:0]   rdata
);

  logic [W-1:0] mem [SIZE];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < SIZE) ? mem[raddr] : '0;

endmodule

// File: rtl/seq_recorder.sv
// Capture buffer: records a word stream (REC) and replays it over a req/valid
// sequential-read handshake (DUMP). Define SEQ_RECORDER_WRAP_EN for ring mode.
module seq_recorder
  import seq_mem_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int SIZE = 256,
  localparam int AW   = idx_width(SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic          dump,
  input  logic          req,
  output logic          valid,
  output logic [W-1:0]  out,
  output logic [AW-1:0] count,
  output logic          busy
);

  localparam int            RAW    = addr_width(SIZE);
  localparam logic [AW-1:0] SIZE_I = AW'(SIZE);
  localparam logic [AW-1:0] ONE    = AW'(1);

  seq_state_t    state, state_nx;
  logic [AW-1:0] wr, rd, wr_nx;
  logic [RAW-1:0] waddr, raddr;
  logic          we, take, start, finish;

  always_comb begin
    state_nx = state;
    case (state)
      ST_REC:  if (dump) state_nx = ST_DUMP;
      ST_DUMP: if (!valid) state_nx = ST_REC;
      default: state_nx = ST_REC;
    endcase
  end

  assign we     = in_valid & in_ready;
  assign take   = req & valid;
  assign start  = (state == ST_REC) & dump;
  assign finish = (state == ST_DUMP) & ~valid;
  assign busy   = (state == ST_DUMP);

`ifdef SEQ_RECORDER_WRAP_EN
  logic [AW-1:0] base, cnt, raddr_w;
  logic [AW:0]   rsum;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] idx);
    return (idx == SIZE_I - ONE) ? '0 : idx + ONE;
  endfunction

  assign in_ready = (state == ST_REC);
  assign valid    = (state == ST_DUMP) && (rd < cnt);
  assign count    = cnt;
  assign wr_nx    = bump(wr);
  assign waddr    = wr[RAW-1:0];

  // Playback starts at the oldest word and wraps around the ring.
  assign rsum    = {1'b0, base} + {1'b0, rd};
  assign raddr_w = (rsum >= {1'b0, SIZE_I}) ? AW'(rsum - {1'b0, SIZE_I}) : rsum[AW-1:0];
  assign raddr   = raddr_w[RAW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      base <= '0;
      cnt  <= '0;
    end else if (finish) begin
      base <= '0;
      cnt  <= '0;
    end else if (we) begin
      if (cnt == SIZE_I) begin
        base <= bump(base);
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end
`else
  assign in_ready = (state == ST_REC) && (wr < SIZE_I);
  assign valid    = (state == ST_DUMP) && (rd < wr);
  assign count    = wr;
  assign wr_nx    = wr + ONE;
  assign waddr    = wr[RAW-1:0];
  assign raddr    = rd[RAW-1:0];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_REC;
      wr    <= '0;
      rd    <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        rd <= '0;
      end else if (take) begin
        rd <= rd + ONE;
      end
      if (finish) begin
        wr <= '0;
      end else if (we) begin
        wr <= wr_nx;
      end
    end
  end

  ram_1w1r #(
    .W    (W),
    .SIZE (SIZE),
    .RAW  (RAW)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (out)
  );

endmodule

// File: tb/tb_seq_recorder.sv
// Bench for seq_recorder (SIZE = 4): directed vector tables plus random traffic
// checked against a queue-based model of the record/playback rules.
module tb_seq_recorder;

  localparam int W    = 8;
  localparam int SIZE = 4;
  localparam int AW   = 3;
`ifdef SEQ_RECORDER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, in_valid, dump, req;
  logic [W-1:0]  in_data;
  logic          in_ready, valid, busy;
  logic [W-1:0]  out;
  logic [AW-1:0] count;

  int total = 0;
  int pass  = 0;

  always #5 clock = ~clock;

  seq_recorder #(.W(W), .SIZE(SIZE)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .dump     (dump),
    .req      (req),
    .valid    (valid),
    .out      (out),
    .count    (count),
    .busy     (busy)
  );

  typedef struct {
    bit       rst;
    bit       iv;
    bit [7:0] id;
    bit       dp;
    bit       rq;
    bit       e_rdy;
    bit       e_vld;
    bit [7:0] e_out;
    int       e_cnt;
    bit       e_busy;
  } vec_t;

  vec_t tbl[$];

  // Reference: stored words as a queue, playback position as an integer.
  bit [7:0] mq[$];
  bit       m_dump = 1'b0;
  int       m_pidx = 0;

  function automatic vec_t mk(bit rst, bit iv, bit [7:0] id, bit dp, bit rq,
                              bit e_rdy, bit e_vld, bit [7:0] e_out, int e_cnt, bit e_busy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.dp = dp; v.rq = rq;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_out = e_out; v.e_cnt = e_cnt; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // mode 0: no check, 1: compare with table values, 2: compare with model.
  task automatic cyc(input vec_t v, input int mode, input string tag);
    bit       m_rdy, m_vld;
    bit [7:0] m_out;
    int       m_cnt;
    reset = v.rst; in_valid = v.iv; in_data = v.id; dump = v.dp; req = v.rq;
    m_rdy = !m_dump && (WRAP || mq.size() < SIZE);
    m_vld = m_dump && (m_pidx < mq.size());
    m_out = m_vld ? mq[m_pidx] : 8'h00;
    m_cnt = mq.size();
    @(negedge clock);
    if (mode == 1) begin
      chk({tag, ".in_ready"}, int'(in_ready), int'(v.e_rdy));
      chk({tag, ".valid"},    int'(valid),    int'(v.e_vld));
      chk({tag, ".count"},    int'(count),    v.e_cnt);
      chk({tag, ".busy"},     int'(busy),     int'(v.e_busy));
      if (v.e_vld) chk({tag, ".out"}, int'(out), int'(v.e_out));
    end else if (mode == 2) begin
      chk({tag, ".in_ready"}, int'(in_ready), int'(m_rdy));
      chk({tag, ".valid"},    int'(valid),    int'(m_vld));
      chk({tag, ".count"},    int'(count),    m_cnt);
      chk({tag, ".busy"},     int'(busy),     int'(m_dump));
      if (m_vld) chk({tag, ".out"}, int'(out), int'(m_out));
    end
    if (v.rst) begin
      mq.delete();
      m_dump = 1'b0;
      m_pidx = 0;
    end else if (!m_dump) begin
      if (v.iv && m_rdy) begin
        if (mq.size() == SIZE) void'(mq.pop_front());
        mq.push_back(v.id);
      end
      if (v.dp) begin
        m_dump = 1'b1;
        m_pidx = 0;
      end
    end else if (!m_vld) begin
      m_dump = 1'b0;
      mq.delete();
    end else if (v.rq) begin
      m_pidx++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; dump = 1'b0; req = 1'b0;

    // Three words then playback; first row also checks the reset state.
    tbl.push_back(mk(0,1,8'h11,0,0, 1,0,8'h00,0,0));
    tbl.push_back(mk(0,1,8'h22,0,0, 1,0,8'h00,1,0));
    tbl.push_back(mk(0,1,8'h33,0,0, 1,0,8'h00,2,0));
    tbl.push_back(mk(0,0,8'h00,1,0, 1,0,8'h00,3,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h11,3,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h22,3,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h33,3,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,0,8'h00,3,1));
    tbl.push_back(mk(0,0,8'h00,0,0, 1,0,8'h00,0,0));
`ifdef SEQ_RECORDER_WRAP_EN
    // Six writes into a four-word ring keep the newest four.
    tbl.push_back(mk(0,1,8'h01,0,0, 1,0,8'h00,0,0));
    tbl.push_back(mk(0,1,8'h02,0,0, 1,0,8'h00,1,0));
    tbl.push_back(mk(0,1,8'h03,0,0, 1,0,8'h00,2,0));
    tbl.push_back(mk(0,1,8'h04,0,0, 1,0,8'h00,3,0));
    tbl.push_back(mk(0,1,8'h05,0,0, 1,0,8'h00,4,0));
    tbl.push_back(mk(0,1,8'h06,0,0, 1,0,8'h00,4,0));
    tbl.push_back(mk(0,0,8'h00,1,0, 1,0,8'h00,4,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h03,4,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h04,4,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h05,4,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h06,4,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,0,8'h00,4,1));
    tbl.push_back(mk(0,0,8'h00,0,0, 1,0,8'h00,0,0));
`else
    // Fill to capacity; the fifth word is held off and never stored.
    tbl.push_back(mk(0,1,8'hA0,0,0, 1,0,8'h00,0,0));
    tbl.push_back(mk(0,1,8'hA1,0,0, 1,0,8'h00,1,0));
    tbl.push_back(mk(0,1,8'hA2,0,0, 1,0,8'h00,2,0));
    tbl.push_back(mk(0,1,8'hA3,0,0, 1,0,8'h00,3,0));
    tbl.push_back(mk(0,1,8'hA4,0,0, 0,0,8'h00,4,0));
    tbl.push_back(mk(0,1,8'hA4,1,0, 0,0,8'h00,4,0));
    tbl.push_back(mk(0,1,8'hA4,0,1, 0,1,8'hA0,4,1));
    tbl.push_back(mk(0,1,8'hA4,0,1, 0,1,8'hA1,4,1));
    tbl.push_back(mk(0,1,8'hA4,0,1, 0,1,8'hA2,4,1));
    tbl.push_back(mk(0,1,8'hA4,0,1, 0,1,8'hA3,4,1));
    tbl.push_back(mk(0,1,8'hA4,0,1, 0,0,8'h00,4,1));
    tbl.push_back(mk(0,0,8'h00,0,0, 1,0,8'h00,0,0));
`endif
    // Write coinciding with dump is included in playback.
    tbl.push_back(mk(0,1,8'h10,0,0, 1,0,8'h00,0,0));
    tbl.push_back(mk(0,1,8'h20,0,0, 1,0,8'h00,1,0));
    tbl.push_back(mk(0,1,8'h55,1,0, 1,0,8'h00,2,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h10,3,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h20,3,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h55,3,1));
    tbl.push_back(mk(0,0,8'h00,0,0, 0,0,8'h00,3,1));
    tbl.push_back(mk(0,0,8'h00,0,0, 1,0,8'h00,0,0));
    // Empty dump: busy for exactly one cycle.
    tbl.push_back(mk(0,0,8'h00,1,0, 1,0,8'h00,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,0,8'h00,0,1));
    tbl.push_back(mk(0,0,8'h00,0,0, 1,0,8'h00,0,0));
    // Reset mid-dump, then a fresh write must replay from address 0.
    tbl.push_back(mk(0,1,8'h61,0,0, 1,0,8'h00,0,0));
    tbl.push_back(mk(0,1,8'h62,0,0, 1,0,8'h00,1,0));
    tbl.push_back(mk(0,1,8'h63,1,0, 1,0,8'h00,2,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h61,3,1));
    tbl.push_back(mk(1,0,8'h00,0,0, 0,1,8'h62,3,1));
    tbl.push_back(mk(0,1,8'h77,0,0, 1,0,8'h00,0,0));
    tbl.push_back(mk(0,0,8'h00,1,0, 1,0,8'h00,1,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,8'h77,1,1));
    tbl.push_back(mk(0,0,8'h00,0,0, 0,0,8'h00,1,1));
    tbl.push_back(mk(0,0,8'h00,0,0, 1,0,8'h00,0,0));

    cyc(mk(1,0,8'h00,0,0, 0,0,8'h00,0,0), 0, "rst");
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i], 1, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 3000; i++) begin
      vec_t r;
      r = mk($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 8'($urandom),
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, 0, 0, 8'h00, 0, 0);
      cyc(r, 2, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/seq_recorder.md
Name: seq_recorder

Overview:
- Write-side counterpart of the sequential ROM reader. It captures a stream of W-bit words into internal memory at incrementing addresses (record).
- On request it plays the captured words back in order through the same req/valid/out sequential-read handshake the ROM reader presents (dump).
- Used as a capture buffer for bring-up traces and as a loader that feeds rom-style consumers.

Parameters:
- W, 8, word width in bits.
- SIZE, 256, capacity in words. Internal index width AW = $clog2(SIZE+1), so the index can hold the value SIZE.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  producer offers in_data this cycle.
- in_data  input  W  word to record.
- in_ready  output  1  recorder accepts in_data this cycle.
- dump  input  1  single-cycle request to start playback.
- req  input  1  consumer takes the current out word.
- valid  output  1  out holds a stored word not yet consumed.
- out  output  W  current playback word.
- count  output  AW  number of words currently stored.
- busy  output  1  high while in DUMP state.

Behaviour:
- Reset:
  - state = REC; write index and read index = 0; count = 0; busy = 0; valid = 0.
  - in_ready = 1; out is undefined (memory contents are not cleared).
- States:
  - REC: accepts input words.
  - DUMP: plays back stored words; in_ready = 0 throughout.
- REC:
  - in_ready = (wr < SIZE).
  - A write occurs when in_valid & in_ready: m[wr] <= in_data and wr <= wr+1 at the same edge. No latency.
  - count = wr.
  - When wr == SIZE, in_ready = 0 (backpressure). The word is held by the producer, never dropped.
- REC -> DUMP when dump = 1:
  - rd <= 0 at that edge and busy = 1 from the next cycle.
  - If in_valid & in_ready coincide with dump, the write is accepted and that word is included in playback.
- DUMP:
  - out = m[rd], combinational read with zero latency.
  - valid = (rd < wr).
  - req & valid -> rd <= rd+1. req while valid = 0 is ignored.
  - dump is ignored while in DUMP.
- DUMP -> REC in the cycle after rd == wr is first observed:
  - wr <= 0, count <= 0, busy <= 0.
  - A dump of an empty buffer enters DUMP with valid = 0 and returns to REC one cycle later.
- Reset during DUMP aborts playback immediately: state REC, both indexes 0.
- Widths: all index arithmetic is AW-bit unsigned. wr and rd never exceed SIZE.

Optional Feature:
- Macro SEQ_RECORDER_WRAP_EN.
- Defined (ring mode):
  - In REC, in_ready = 1 always.
  - When full, each accepted write overwrites the oldest word.
  - Write pointer wraps modulo SIZE; a base pointer tracks the oldest word; count saturates at SIZE.
  - DUMP starts at the base and emits count words, with addressing wrapping modulo SIZE.
- Undefined: the backpressure behaviour above. No base pointer logic is synthesised.

Decomposition:
- Package seq_mem_pkg holds:
  - state encodings ST_REC and ST_DUMP;
  - an AW-width helper function, shared with the sequential ROM.
- One natural sub-module: ram_1w1r, a W x SIZE memory with a synchronous write port and an asynchronous read port. The recorder contains only the FSM, pointers and handshake.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 with in_valid held, then pulse dump:
  - count = 3, busy = 1;
  - out = 0x11, 0x22, 0x33 on successive req cycles;
  - valid drops after the third word, then busy = 0 and count = 0.
- Fill SIZE = 4 with 0xA0..0xA3, keep in_valid = 1 with 0xA4:
  - in_ready = 0 after the 4th word and count = 4;
  - dump returns 0xA0..0xA3 only.
- in_valid = 1 with 0x55 in the same cycle as dump after 2 words: 3 words are played back, the last being 0x55.
- Dump on an empty buffer: valid stays 0; busy is 1 for exactly one cycle, then in_ready = 1.
- Reset asserted mid-dump after 1 of 3 words:
  - next cycle busy = 0, count = 0, valid = 0;
  - a new write then lands at address 0.
- With SEQ_RECORDER_WRAP_EN, SIZE = 4: write 0x1..0x6, then dump. Output must be 0x3, 0x4, 0x5, 0x6 with count = 4.
